// File: rtl/mpx_arbiter.sv
// Round-robin arbiter driving the 4-way one-hot datapath mux select.
// Grants are held while requested, up to MAX_HOLD cycles, with an idle bubble between owners.
module mpx_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] sel,
  output logic [1:0] owner,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {StIdle, StGrant} state_e;

  localparam int unsigned HoldLastI = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HoldLastI);
  localparam logic [HOLD_W-1:0] HoldMax  = '1;

  state_e              r_state, w_state_nxt;
  logic [3:0]          r_sel, w_sel_nxt;
  logic [1:0]          r_owner, w_owner_nxt;
  logic [1:0]          r_ptr, w_ptr_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_preempt, w_preempt_nxt;

  logic                w_found;
  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic                w_release;
  logic                w_timeout;

  // First requester at or after the round-robin pointer, wrapping modulo 4.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_release = !req[r_owner];
  assign w_timeout = (MAX_HOLD != 0) && (r_hold == HoldLast);

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_busy_nxt    = r_busy;
    w_preempt_nxt = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_state_nxt = StGrant;
          w_sel_nxt   = 4'b0001 << w_win;
          w_owner_nxt = w_win;
          w_ptr_nxt   = w_win + 2'd1;
          w_hold_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      StGrant: begin
        if (w_release || w_timeout) begin
          w_state_nxt   = StIdle;
          w_sel_nxt     = 4'b0000;
          w_busy_nxt    = 1'b0;
          // Voluntary release wins a tie with the hold limit, so no pulse then.
          w_preempt_nxt = !w_release;
        end else if (r_hold != HoldMax) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_sel     <= 4'b0000;
      r_owner   <= 2'd0;
      r_ptr     <= 2'd0;
      r_hold    <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_busy    <= w_busy_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign sel     = r_sel;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_mpx_arbiter.sv
// Scoreboarded bench for mpx_arbiter: three instances (hold limits 16, 4, disabled) share stimulus
// and are checked every cycle against a grant-level reference model.
module tb_mpx_arbiter;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] own;
    logic       busy;
    logic       pre;
  } exp_t;

  localparam int NDut = 3;
  localparam int Lim[NDut] = '{16, 4, 0};

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] sel_w [NDut];
  logic [1:0] own_w [NDut];
  logic       busy_w[NDut];
  logic       pre_w [NDut];

  int n_tests;
  int n_fail;

  // Reference model: grant active flag, owner, next-priority index, cycles shown so far.
  int   m_act[NDut];
  int   m_own[NDut];
  int   m_ptr[NDut];
  int   m_cnt[NDut];
  int   m_pre[NDut];
  exp_t q[NDut][$];

  mpx_arbiter #(.MAX_HOLD(16), .HOLD_W(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel_w[0]), .owner(own_w[0]), .busy(busy_w[0]), .preempt(pre_w[0])
  );
  mpx_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel_w[1]), .owner(own_w[1]), .busy(busy_w[1]), .preempt(pre_w[1])
  );
  mpx_arbiter #(.MAX_HOLD(0), .HOLD_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel_w[2]), .owner(own_w[2]), .busy(busy_w[2]), .preempt(pre_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h want %0h", nm, d, $time, act, exp);
    end
  endtask

  // Model step and scoreboard push at each active edge.
  always @(posedge clk) begin
    for (int d = 0; d < NDut; d++) begin
      exp_t e;
      m_pre[d] = 0;
      if (!rst_n) begin
        m_act[d] = 0;
        m_own[d] = 0;
        m_ptr[d] = 0;
        m_cnt[d] = 0;
      end else if (m_act[d] == 0) begin
        if (req != 4'b0000) begin
          for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_ptr[d] + i) % 4;
            if (m_act[d] == 0 && req[c]) begin
              m_act[d] = 1;
              m_own[d] = c;
              m_cnt[d] = 1;
            end
          end
          m_ptr[d] = (m_own[d] + 1) % 4;
        end
      end else begin
        if (!req[m_own[d]]) begin
          m_act[d] = 0;
        end else if (Lim[d] != 0 && m_cnt[d] == Lim[d]) begin
          m_act[d] = 0;
          m_pre[d] = 1;
        end else begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
      e.sel  = (m_act[d] != 0) ? 4'(1 << m_own[d]) : 4'b0000;
      e.own  = 2'(m_own[d]);
      e.busy = (m_act[d] != 0);
      e.pre  = (m_pre[d] != 0);
      q[d].push_back(e);
    end
  end

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < NDut; d++) begin
      exp_t e;
      if (q[d].size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty dut%0d t=%0t: got 0 entries want 1", d, $time);
      end else begin
        e = q[d].pop_front();
        if (!rst_n) begin
          e = '0;
        end
        check("sel", d, {4'b0, sel_w[d]}, {4'b0, e.sel});
        check("owner", d, {6'b0, own_w[d]}, {6'b0, e.own});
        check("busy", d, {7'b0, busy_w[d]}, {7'b0, e.busy});
        check("preempt", d, {7'b0, pre_w[d]}, {7'b0, e.pre});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 4'b1111;

    // Reset held with all requests; first edge after release grants source 0.
    step(3);
    rst_n = 1'b1;
    step(4);

    // Single request, dropped after a few grant cycles.
    req = 4'b0000;
    step(3);
    req = 4'b0100;
    step(6);
    req = 4'b0000;
    step(3);

    // Full contention: rotation and hold-limit preemption.
    req = 4'b1111;
    step(30);
    req = 4'b0000;
    step(3);

    // Partial requests on sources 0 and 2.
    for (int i = 0; i < 40; i++) begin
      req = 4'(($urandom_range(0, 3) == 0) ? 4'b0000 : 4'b0101) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) req = 4'b0101;
      step(1);
    end
    req = 4'b0000;
    step(3);

    // Reset asserted mid-grant to source 2, then re-arbitration from ptr 0.
    req = 4'b0100;
    step(3);
    rst_n = 1'b0;
    req   = 4'b1010;
    step(1);
    rst_n = 1'b1;
    step(5);
    req = 4'b0000;
    step(3);

    // Long single request: only the disabled-limit instance never releases.
    req = 4'b0010;
    step(300);
    req = 4'b0000;
    step(3);

    // Release coinciding with the 4-cycle hold limit.
    req = 4'b0001;
    step(4);
    req = 4'b0000;
    step(3);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
      end
      step(1);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
